// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: load-use interlock, branch squash,
// DM wait with timeout, post-reset fetch hold and saturating event counters.
module pipe_hazard_ctrl #(
  parameter int REG_ADDR_W  = 5,
  parameter int CNT_W       = 16,
  parameter int RESET_HOLD  = 2,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cnt_clr,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] exe_write_addr,
  input  logic                  exe_DM_read,
  input  logic                  exe_branch_taken,
  input  logic                  mem_dm_req,
  input  logic                  mem_dm_ready,
  output logic                  pc_stall,
  output logic                  if_id_stall,
  output logic                  id_exe_stall,
  output logic                  exe_mem_stall,
  output logic                  if_id_flush,
  output logic                  id_exe_flush,
  output logic                  mem_wb_flush,
  output logic                  mem_err,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  localparam int HOLD_W = $clog2(RESET_HOLD + 2);
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 2);

  typedef enum logic [1:0] {S_HOLD, S_RUN, S_MEM_WAIT} state_t;

  localparam state_t             RST_STATE = (RESET_HOLD == 0) ? S_RUN : S_HOLD;
  localparam logic [HOLD_W-1:0]  HOLD_INIT = HOLD_W'(RESET_HOLD);
  localparam logic [WAIT_W-1:0]  WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_t              r_state;
  logic [HOLD_W-1:0]   r_hold_cnt;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic [CNT_W-1:0]    r_stall_cnt;
  logic [CNT_W-1:0]    r_flush_cnt;
  logic                r_mem_err;

  logic                w_memwait;
  logic                w_rs1_hit;
  logic                w_rs2_hit;
  logic                w_lu;
  logic                w_hold;
  logic                w_stall_evt;
  logic                w_flush_evt;
  logic [WAIT_W-1:0]   w_wait_nxt;

  assign w_memwait  = mem_dm_req & ~mem_dm_ready;
  assign w_rs1_hit  = id_rs1_used & (id_rs1_addr == exe_write_addr);
  assign w_rs2_hit  = id_rs2_used & (id_rs2_addr == exe_write_addr);
  assign w_lu       = exe_DM_read & (exe_write_addr != '0) & (w_rs1_hit | w_rs2_hit);
  // rst term keeps the HOLD controls visible during reset even when RESET_HOLD=0
  assign w_hold     = rst | (r_state == S_HOLD);
  assign w_wait_nxt = (r_wait_cnt == WAIT_MAX) ? WAIT_MAX : r_wait_cnt + WAIT_W'(1);

  always_comb begin
    pc_stall      = 1'b0;
    if_id_stall   = 1'b0;
    id_exe_stall  = 1'b0;
    exe_mem_stall = 1'b0;
    if_id_flush   = 1'b0;
    id_exe_flush  = 1'b0;
    mem_wb_flush  = 1'b0;
    w_flush_evt   = 1'b0;
    if (w_hold) begin
      pc_stall     = 1'b1;
      if_id_flush  = 1'b1;
      id_exe_flush = 1'b1;
    end else if (w_memwait) begin
      // a taken branch stays parked in EXE behind the frozen EXE/MEM register
      pc_stall      = 1'b1;
      if_id_stall   = 1'b1;
      id_exe_stall  = 1'b1;
      exe_mem_stall = 1'b1;
      mem_wb_flush  = 1'b1;
    end else if (exe_branch_taken) begin
      if_id_flush  = 1'b1;
      id_exe_flush = 1'b1;
      w_flush_evt  = 1'b1;
    end else if (w_lu) begin
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_exe_flush = 1'b1;
    end
  end

  assign w_stall_evt = ~w_hold & pc_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= RST_STATE;
      r_hold_cnt  <= HOLD_INIT;
      r_wait_cnt  <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
      r_mem_err   <= 1'b0;
    end else begin
      case (r_state)
        S_HOLD: begin
          if (r_hold_cnt != '0) r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
          if (r_hold_cnt <= HOLD_W'(1)) r_state <= S_RUN;
        end
        S_RUN, S_MEM_WAIT: begin
          if (w_memwait) begin
            r_state    <= S_MEM_WAIT;
            r_wait_cnt <= w_wait_nxt;
            if (w_wait_nxt == WAIT_MAX) r_mem_err <= 1'b1;
          end else begin
            r_state    <= S_RUN;
            r_wait_cnt <= '0;
          end
        end
        default: r_state <= RST_STATE;
      endcase
      // clear is placed last so it wins over a same-cycle increment or timeout
      if (cnt_clr) begin
        r_stall_cnt <= '0;
        r_flush_cnt <= '0;
        r_mem_err   <= 1'b0;
      end else begin
        if (w_stall_evt) r_stall_cnt <= sat_inc(r_stall_cnt);
        if (w_flush_evt) r_flush_cnt <= sat_inc(r_flush_cnt);
      end
    end
  end

  assign mem_err   = r_mem_err;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with RESET_HOLD=2, MEM_TIMEOUT=4, CNT_W=2.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cnt_clr;
  logic [4:0] id_rs1_addr, id_rs2_addr, exe_write_addr;
  logic       id_rs1_used, id_rs2_used;
  logic       exe_DM_read, exe_branch_taken, mem_dm_req, mem_dm_ready;
  logic       pc_stall, if_id_stall, id_exe_stall, exe_mem_stall;
  logic       if_id_flush, id_exe_flush, mem_wb_flush, mem_err;
  logic [1:0] stall_cnt, flush_cnt;

  int checks   = 0;
  int failures = 0;

  // {pc_stall, if_id_stall, id_exe_stall, exe_mem_stall, if_id_flush, id_exe_flush, mem_wb_flush}
  localparam logic [6:0] C_HOLD = 7'b1000_110;
  localparam logic [6:0] C_MEMW = 7'b1111_001;
  localparam logic [6:0] C_BR   = 7'b0000_110;
  localparam logic [6:0] C_LU   = 7'b1100_010;
  localparam logic [6:0] C_NONE = 7'b0000_000;

  wire [6:0] w_ctrl = {pc_stall, if_id_stall, id_exe_stall, exe_mem_stall,
                       if_id_flush, id_exe_flush, mem_wb_flush};

  pipe_hazard_ctrl #(
    .REG_ADDR_W (5),
    .CNT_W      (2),
    .RESET_HOLD (2),
    .MEM_TIMEOUT(4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .cnt_clr         (cnt_clr),
    .id_rs1_addr     (id_rs1_addr),
    .id_rs2_addr     (id_rs2_addr),
    .id_rs1_used     (id_rs1_used),
    .id_rs2_used     (id_rs2_used),
    .exe_write_addr  (exe_write_addr),
    .exe_DM_read     (exe_DM_read),
    .exe_branch_taken(exe_branch_taken),
    .mem_dm_req      (mem_dm_req),
    .mem_dm_ready    (mem_dm_ready),
    .pc_stall        (pc_stall),
    .if_id_stall     (if_id_stall),
    .id_exe_stall    (id_exe_stall),
    .exe_mem_stall   (exe_mem_stall),
    .if_id_flush     (if_id_flush),
    .id_exe_flush    (id_exe_flush),
    .mem_wb_flush    (mem_wb_flush),
    .mem_err         (mem_err),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    cnt_clr = 0; id_rs1_addr = 0; id_rs2_addr = 0; exe_write_addr = 0;
    id_rs1_used = 0; id_rs2_used = 0; exe_DM_read = 0; exe_branch_taken = 0;
    mem_dm_req = 0; mem_dm_ready = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Leaves the DUT in RUN, 1 time unit after a rising edge.
  task automatic apply_reset();
    clear_inputs();
    rst = 1; #2;
    @(negedge clk); rst = 0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1; #7;
    checks++; if (w_ctrl !== C_HOLD) begin failures++; $display("FAIL reset_ctrl got=%b exp=%b", w_ctrl, C_HOLD); end
    checks++; if (stall_cnt !== 2'd0) begin failures++; $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cnt); end
    checks++; if (flush_cnt !== 2'd0) begin failures++; $display("FAIL reset_flush_cnt got=%0d exp=0", flush_cnt); end
    checks++; if (mem_err !== 1'b0) begin failures++; $display("FAIL reset_mem_err got=%b exp=0", mem_err); end
    exe_branch_taken = 1; exe_DM_read = 1; exe_write_addr = 3; id_rs1_used = 1; id_rs1_addr = 3;
    @(negedge clk); rst = 0; #1;
    checks++; if (w_ctrl !== C_HOLD) begin failures++; $display("FAIL hold_cycle1 got=%b exp=%b", w_ctrl, C_HOLD); end
    tick();
    checks++; if (w_ctrl !== C_HOLD) begin failures++; $display("FAIL hold_cycle2 got=%b exp=%b", w_ctrl, C_HOLD); end
    tick();
    clear_inputs(); #1;
    checks++; if (w_ctrl !== C_NONE) begin failures++; $display("FAIL hold_release got=%b exp=%b", w_ctrl, C_NONE); end
    checks++; if (stall_cnt !== 2'd0) begin failures++; $display("FAIL hold_stall_cnt got=%0d exp=0", stall_cnt); end
    checks++; if (flush_cnt !== 2'd0) begin failures++; $display("FAIL hold_flush_cnt got=%0d exp=0", flush_cnt); end
  endtask

  task automatic test_load_use();
    apply_reset();
    exe_DM_read = 1; exe_write_addr = 5; id_rs2_used = 1; id_rs2_addr = 5; #1;
    checks++; if (w_ctrl !== C_LU) begin failures++; $display("FAIL lu_rs2 got=%b exp=%b", w_ctrl, C_LU); end
    tick();
    clear_inputs(); #1;
    checks++; if (stall_cnt !== 2'd1) begin failures++; $display("FAIL lu_stall_cnt got=%0d exp=1", stall_cnt); end
    checks++; if (w_ctrl !== C_NONE) begin failures++; $display("FAIL lu_one_cycle got=%b exp=%b", w_ctrl, C_NONE); end
    exe_DM_read = 1; exe_write_addr = 0; id_rs2_used = 1; id_rs2_addr = 0; #1;
    checks++; if (w_ctrl !== C_NONE) begin failures++; $display("FAIL lu_x0 got=%b exp=%b", w_ctrl, C_NONE); end
    tick();
    checks++; if (stall_cnt !== 2'd1) begin failures++; $display("FAIL lu_x0_cnt got=%0d exp=1", stall_cnt); end
    clear_inputs();
    exe_DM_read = 1; exe_write_addr = 7; id_rs1_used = 1; id_rs1_addr = 7; #1;
    checks++; if (w_ctrl !== C_LU) begin failures++; $display("FAIL lu_rs1 got=%b exp=%b", w_ctrl, C_LU); end
    id_rs1_used = 0; #1;
    checks++; if (w_ctrl !== C_NONE) begin failures++; $display("FAIL lu_unused got=%b exp=%b", w_ctrl, C_NONE); end
    id_rs1_used = 1; exe_DM_read = 0; #1;
    checks++; if (w_ctrl !== C_NONE) begin failures++; $display("FAIL lu_not_load got=%b exp=%b", w_ctrl, C_NONE); end
    id_rs2_used = 1; id_rs2_addr = 6; exe_DM_read = 1; id_rs1_addr = 8; #1;
    checks++; if (w_ctrl !== C_NONE) begin failures++; $display("FAIL lu_addr_miss got=%b exp=%b", w_ctrl, C_NONE); end
    tick();
    clear_inputs();
    checks++; if (stall_cnt !== 2'd1) begin failures++; $display("FAIL lu_final_cnt got=%0d exp=1", stall_cnt); end
  endtask

  task automatic test_branch_vs_lu();
    apply_reset();
    exe_branch_taken = 1; exe_DM_read = 1; exe_write_addr = 9; id_rs1_used = 1; id_rs1_addr = 9; #1;
    checks++; if (w_ctrl !== C_BR) begin failures++; $display("FAIL br_over_lu got=%b exp=%b", w_ctrl, C_BR); end
    tick();
    clear_inputs(); #1;
    checks++; if (flush_cnt !== 2'd1) begin failures++; $display("FAIL br_flush_cnt got=%0d exp=1", flush_cnt); end
    checks++; if (stall_cnt !== 2'd0) begin failures++; $display("FAIL br_stall_cnt got=%0d exp=0", stall_cnt); end
  endtask

  task automatic test_dm_wait_branch();
    apply_reset();
    mem_dm_req = 1; mem_dm_ready = 0; exe_branch_taken = 1; #1;
    for (int i = 1; i <= 3; i++) begin
      checks++; if (w_ctrl !== C_MEMW) begin failures++; $display("FAIL dmw_cycle%0d got=%b exp=%b", i, w_ctrl, C_MEMW); end
      tick();
    end
    mem_dm_ready = 1; #1;
    checks++; if (w_ctrl !== C_BR) begin failures++; $display("FAIL dmw_release got=%b exp=%b", w_ctrl, C_BR); end
    tick();
    clear_inputs(); #1;
    checks++; if (stall_cnt !== 2'd3) begin failures++; $display("FAIL dmw_stall_cnt got=%0d exp=3", stall_cnt); end
    checks++; if (flush_cnt !== 2'd1) begin failures++; $display("FAIL dmw_flush_cnt got=%0d exp=1", flush_cnt); end
    checks++; if (mem_err !== 1'b0) begin failures++; $display("FAIL dmw_no_timeout got=%b exp=0", mem_err); end
    checks++; if (w_ctrl !== C_NONE) begin failures++; $display("FAIL dmw_idle got=%b exp=%b", w_ctrl, C_NONE); end
  endtask

  task automatic test_timeout();
    logic exp_err;
    apply_reset();
    mem_dm_req = 1; mem_dm_ready = 0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      exp_err = (i >= 4);
      checks++; if (mem_err !== exp_err) begin failures++; $display("FAIL to_err_after%0d got=%b exp=%b", i, mem_err, exp_err); end
    end
    mem_dm_ready = 1; #1;
    checks++; if (w_ctrl !== C_NONE) begin failures++; $display("FAIL to_release got=%b exp=%b", w_ctrl, C_NONE); end
    tick();
    clear_inputs(); #1;
    checks++; if (mem_err !== 1'b1) begin failures++; $display("FAIL to_sticky got=%b exp=1", mem_err); end
    checks++; if (stall_cnt !== 2'd3) begin failures++; $display("FAIL to_stall_cnt got=%0d exp=3", stall_cnt); end
    cnt_clr = 1; exe_DM_read = 1; exe_write_addr = 4; id_rs1_used = 1; id_rs1_addr = 4;
    tick();
    clear_inputs(); #1;
    checks++; if (mem_err !== 1'b0) begin failures++; $display("FAIL clr_mem_err got=%b exp=0", mem_err); end
    checks++; if (stall_cnt !== 2'd0) begin failures++; $display("FAIL clr_stall_cnt got=%0d exp=0", stall_cnt); end
    checks++; if (flush_cnt !== 2'd0) begin failures++; $display("FAIL clr_flush_cnt got=%0d exp=0", flush_cnt); end
  endtask

  task automatic test_sat_async_reset();
    logic [1:0] exp_cnt;
    apply_reset();
    exe_DM_read = 1; exe_write_addr = 2; id_rs2_used = 1; id_rs2_addr = 2; #1;
    checks++; if (w_ctrl !== C_LU) begin failures++; $display("FAIL sat_lu got=%b exp=%b", w_ctrl, C_LU); end
    for (int i = 1; i <= 5; i++) begin
      tick();
      exp_cnt = (i > 3) ? 2'd3 : 2'(i);
      checks++; if (stall_cnt !== exp_cnt) begin failures++; $display("FAIL sat_cnt%0d got=%0d exp=%0d", i, stall_cnt, exp_cnt); end
    end
    clear_inputs();
    mem_dm_req = 1; mem_dm_ready = 0;
    tick();
    tick();
    #2 rst = 1; #1;
    checks++; if (w_ctrl !== C_HOLD) begin failures++; $display("FAIL arst_ctrl got=%b exp=%b", w_ctrl, C_HOLD); end
    checks++; if (stall_cnt !== 2'd0) begin failures++; $display("FAIL arst_stall_cnt got=%0d exp=0", stall_cnt); end
    clear_inputs();
    @(negedge clk); rst = 0; #1;
    checks++; if (w_ctrl !== C_HOLD) begin failures++; $display("FAIL arst_hold got=%b exp=%b", w_ctrl, C_HOLD); end
  endtask

  initial begin
    rst = 1;
    clear_inputs();
    test_reset();
    test_load_use();
    test_branch_vs_lu();
    test_dm_wait_branch();
    test_timeout();
    test_sat_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central pipeline sequencer for the 5-stage core.
- Watches the ID operands, the EXE load/branch status and the MEM-stage data-memory handshake.
- Drives the stall and flush controls of the PC, IF/ID, ID/EXE, EXE/MEM and MEM/WB registers.
- Handles three events:
  - load-use interlock;
  - taken-branch squash;
  - multi-cycle DM wait with timeout.
- Also provides a post-reset fetch hold and saturating stall/flush event counters.

Parameters:
- REG_ADDR_W, 5, register-file address width.
- CNT_W, 16, width of the stall and flush event counters.
- RESET_HOLD, 2, number of cycles the pipeline is held and flushed after reset deasserts; 0 means no hold.
- MEM_TIMEOUT, 255, number of consecutive DM-wait cycles before mem_err is raised.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- cnt_clr  in  1  synchronous clear of stall_cnt, flush_cnt and mem_err.
- id_rs1_addr  in  REG_ADDR_W  ID source register 1.
- id_rs2_addr  in  REG_ADDR_W  ID source register 2.
- id_rs1_used  in  1  ID instruction reads rs1.
- id_rs2_used  in  1  ID instruction reads rs2.
- exe_write_addr  in  REG_ADDR_W  EXE destination register.
- exe_DM_read  in  1  instruction in EXE is a load.
- exe_branch_taken  in  1  branch in EXE resolved taken.
- mem_dm_req  in  1  MEM stage is accessing DM.
- mem_dm_ready  in  1  DM access completes this cycle.
- pc_stall  out  1  hold the PC.
- if_id_stall  out  1  hold the IF/ID register.
- id_exe_stall  out  1  hold the ID/EXE register.
- exe_mem_stall  out  1  hold the EXE/MEM register.
- if_id_flush  out  1  load a NOP into IF/ID.
- id_exe_flush  out  1  load a NOP into ID/EXE (the existing flush input).
- mem_wb_flush  out  1  load a bubble into MEM/WB.
- mem_err  out  1  sticky DM-timeout flag.
- stall_cnt  out  CNT_W  cycles with pc_stall=1 in RUN or MEM_WAIT.
- flush_cnt  out  CNT_W  branch flushes issued.

Behaviour:
- Reset values:
  - FSM state = HOLD (RUN if RESET_HOLD=0); hold_cnt = RESET_HOLD; wait_cnt = 0.
  - stall_cnt = 0, flush_cnt = 0, mem_err = 0.
  - Control outputs during reset take their HOLD-state values.
- Control outputs are combinational from the current state and inputs, so they take effect at the next clock edge (zero-cycle decision latency). Counters, mem_err, state, hold_cnt and wait_cnt are registered.
- Definitions:
  - memwait = mem_dm_req & ~mem_dm_ready.
  - lu = exe_DM_read & (exe_write_addr != 0) & ((id_rs1_used & id_rs1_addr == exe_write_addr) | (id_rs2_used & id_rs2_addr == exe_write_addr)).
  - Register x0 never causes a load-use interlock.
- HOLD state:
  - Outputs: pc_stall=1, if_id_flush=1, id_exe_flush=1; all other controls 0.
  - hold_cnt decrements each cycle; when hold_cnt reaches 1, move to RUN. HOLD therefore lasts exactly RESET_HOLD cycles.
  - All event inputs are ignored and counters do not count.
- RUN and MEM_WAIT states, controls in priority order:
  1. memwait: pc/if_id/id_exe/exe_mem stalls all =1, mem_wb_flush=1, both flushes=0. The state is MEM_WAIT next cycle. A taken branch is held in EXE and acted on after the wait.
  2. exe_branch_taken: if_id_flush=1, id_exe_flush=1, all stalls=0, flush_cnt+1. This overrides lu because the ID instruction is squashed anyway.
  3. lu: pc_stall=1, if_id_stall=1, id_exe_flush=1 (one bubble); all other controls 0. No state change is needed, because the load leaves EXE on the next edge.
  4. Otherwise all controls are 0.
- MEM_WAIT state:
  - wait_cnt increments each cycle that memwait=1.
  - When ~memwait: return to RUN and clear wait_cnt. That cycle evaluates priorities 2–4 normally.
  - When wait_cnt reaches MEM_TIMEOUT: set mem_err=1 (sticky) and keep waiting. There is no forced release.
- Counters:
  - Saturate at all-ones; no wrap-around.
  - stall_cnt increments for every RUN/MEM_WAIT cycle with pc_stall=1.
  - cnt_clr takes priority over increment in the same cycle. It does not affect the FSM.
- Asynchronous reset mid-wait or mid-hold returns all registers to their reset values immediately. The pending DM access is abandoned.

Test Plan:
- Reset-hold: RESET_HOLD=2, release rst → pc_stall=if_id_flush=id_exe_flush=1 for exactly 2 cycles, then all controls 0 and stall_cnt=0.
- Load-use: exe_DM_read=1, exe_write_addr=5, id_rs2_used=1, id_rs2_addr=5 → one cycle of pc_stall=if_id_stall=id_exe_flush=1, stall_cnt=1. Repeat with exe_write_addr=0 → no stall.
- Branch vs. load-use: exe_branch_taken=1 together with a lu match → if_id_flush=id_exe_flush=1, pc_stall=0, flush_cnt=1.
- DM wait with branch: mem_dm_req=1, mem_dm_ready low for 3 cycles, exe_branch_taken=1 throughout → 3 cycles of full stall with mem_wb_flush=1 and no flush; in the 4th cycle (ready=1) the branch flush fires. Expect stall_cnt=3, flush_cnt=1.
- Timeout: MEM_TIMEOUT=4, mem_dm_ready held low for 6 cycles → mem_err rises after the 4th wait cycle and stays 1 after ready; cnt_clr → mem_err=0 and both counters 0.
- Saturation and async reset: CNT_W=2, 5 stall cycles → stall_cnt=3. Assert rst mid-MEM_WAIT → counters 0 and state HOLD without waiting for a clock edge.
